ram_latency_ctrl: RTL and testbench
===================================

// Module: ram_latency_ctrl
// PURPOSE
//  Backing-store model for the cpu_ram_if: consumes memaddr/memstore/memREN/memWEN
//  from the core's memory controller and returns ramload/ramstate. Imposes a
//  parameterised access latency so the upstream controller's wait handling is
//  exercised. Word-addressed internal array; each request completes after LAT
//  stable cycles.
// PARAMETERS
//  LAT     2       BUSY cycles before ACCESS; legal range 1..15
//  DEPTH   16384   array size in 32-bit words; power of two
//  ADDR_W  32      width of memaddr
// PORTS
//  CLK       in   1       clock; all state updates on posedge
//  RST       in   1       synchronous, active-high reset
//  memaddr   in   ADDR_W  byte address; bits [1:0] ignored
//  memstore  in   32      write data
//  memREN    in   1       read request, level, held until ACCESS seen
//  memWEN    in   1       write request, level, held until ACCESS seen
//  ramload   out  32      read data; valid while ramstate==ACCESS on a read
//  ramstate  out  2       ramstate_t: FREE, BUSY, ACCESS, ERROR
//  rd_count  out  32      (RAM_STATS_EN only) completed reads
//  wr_count  out  32      (RAM_STATS_EN only) completed writes
// BEHAVIOUR
//  - Reset: key_q<=0, cnt_q<=0, ramload<=0, stats<=0. Array contents are not reset.
//    ramstate is combinational and reads FREE while RST is high.
//  - active = memREN|memWEN; key = {memREN,memWEN,memaddr,memstore}.
//  - hold = active && key==key_q; age = hold ? cnt_q : 0.
//  - ramstate (combinational), first match wins: !active->FREE;
//    memREN&&memWEN->ERROR; word index >= DEPTH->ERROR; age<LAT->BUSY; else ACCESS.
//  - Next state: key_q<=key. cnt_q<=hold ? min(cnt_q+1, LAT+1) : (active ? 1 : 0).
//    The saturation value LAT+1 marks a request as already committed.
//  - Read: when a legal read has age==LAT-1, ramload<=mem[idx] at that edge.
//    ACCESS therefore first asserts in cycle t+LAT for a request presented in
//    cycle t. ramload then holds its value until the next read capture.
//  - Write: mem[idx]<=memstore only at the edge ending the cycle with age==LAT.
//    Holding WEN longer never rewrites, and a write never changes ramload.
//  - Any change of addr, data, REN or WEN mid-count restarts the latency (age=0).
//    No partial write occurs. ERROR requests never touch the array or ramload.
//  - RST asserted mid-request aborts it. No write is committed on that edge,
//    even if age==LAT.
//  - Back-to-back requests with different keys get a full LAT each; there is no
//    idle cycle requirement.
// CONFIGURATION
//  RAM_STATS_EN defined: rd_count/wr_count ports exist. Each increments once per
//    request on the cycle its ramstate first becomes ACCESS (age==LAT). Counters
//    wrap at 2^32 and clear on RST.
//  RAM_STATS_EN undefined: the ports and counters are absent; everything else
//    is identical.
// STRUCTURE
//  - cpu_types_pkg supplies ramstate_t and word_t.
//  - Add a localparam LAT_MAX=15 and typedef ram_cnt_t (logic [4:0]) to
//    cpu_types_pkg.
//  - Sub-module ram_array: DEPTH x 32, one sync write port and one registered
//    read port with explicit enables. Controller FSM/counter and stats stay in
//    ram_latency_ctrl.
// TESTING
//  1 LAT=2, REN addr 0x10 from cycle 0 (mem[4]=0xDEADBEEF) -> BUSY c0,c1;
//    ACCESS c2, ramload=0xDEADBEEF.
//  2 WEN addr 0x20 data 0x12345678, held 6 cycles -> ACCESS c2..c5, exactly one
//    array write; then REN 0x20 -> ACCESS at +2, ramload=0x12345678.
//  3 REN 0x10 cycle 0, addr changes to 0x14 in cycle 1 -> BUSY c0..c2,
//    ACCESS c3, ramload=mem[5].
//  4 REN=WEN=1 -> ERROR immediately; addr 0x10000 with DEPTH=16384 -> ERROR;
//    array and ramload unchanged.
//  5 WEN 0x30 data 0xA5A5A5A5, RST=1 in cycle 2 (age==LAT) -> mem[12] not
//    written; ramstate FREE; later read returns the old value.
//  6 RAM_STATS_EN: 3 reads + 2 writes back-to-back, each held through ACCESS
//    -> rd_count=3, wr_count=2; after RST both 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory interface types: RAM handshake states, data word, latency counter.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;

   localparam int LAT_MAX = 15;

   // Wide enough to hold LAT_MAX+1, the "already committed" saturation mark.
   typedef logic [4:0] ram_cnt_t;

   function automatic ram_cnt_t satInc(input ram_cnt_t c, input ram_cnt_t lim);
      return (c >= lim) ? lim : ram_cnt_t'(c + 5'd1);
   endfunction

endpackage

// File: rtl/ram_array.sv
// Word-addressed storage: one synchronous write port and one registered read port.
// Contents are deliberately not reset; only the read register clears on reset.
module ram_array
   import cpu_types_pkg::*;
#(
   parameter int DEPTH = 16384,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wrEn_i,
   input  logic [IDX_W-1:0] wrAddr_i,
   input  word_t            wrData_i,
   input  logic             rdEn_i,
   input  logic [IDX_W-1:0] rdAddr_i,
   output word_t            rdData_o
);

   word_t mem [DEPTH];
   word_t rdData_q;

   always_ff @(posedge clk_i) begin
      if (wrEn_i) begin
         mem[wrAddr_i] <= wrData_i;
      end
   end

   // Read data only moves on an explicit capture, so it holds between reads.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdData_q <= '0;
      end else if (rdEn_i) begin
         rdData_q <= mem[rdAddr_i];
      end
   end

   assign rdData_o = rdData_q;

endmodule

// File: rtl/ram_latency_ctrl.sv
// Latency-imposing RAM model for the cpu_ram_if handshake.
// Optional RAM_STATS_EN macro adds rd_count/wr_count completion counters.
module ram_latency_ctrl
   import cpu_types_pkg::*;
#(
   parameter int LAT    = 2,
   parameter int DEPTH  = 16384,
   parameter int ADDR_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] memaddr,
   input  word_t             memstore,
   input  logic              memREN,
   input  logic              memWEN,
   output word_t             ramload,
   output ramstate_t         ramstate
`ifdef RAM_STATS_EN
  ,output logic [31:0]       rd_count,
   output logic [31:0]       wr_count
`endif
);

   localparam int       IDX_W = $clog2(DEPTH);
   localparam int       KEY_W = ADDR_W + 34;
   localparam ram_cnt_t LAT_C   = ram_cnt_t'(LAT);
   localparam ram_cnt_t LAT_M1  = ram_cnt_t'(LAT - 1);
   localparam ram_cnt_t LAT_SAT = ram_cnt_t'(LAT + 1);

   logic [KEY_W-1:0] key;
   logic [KEY_W-1:0] key_q, key_d;
   ram_cnt_t         cnt_q, cnt_d;
   ram_cnt_t         age;

   logic             active;
   logic             hold;
   logic             conflict;
   logic             outOfRange;
   logic             legal;
   logic             firstAccess;
   logic             rdCapture;
   logic             wrCommit;
   logic [IDX_W-1:0] wordIdx;

   assign active   = memREN | memWEN;
   assign conflict = memREN & memWEN;
   assign key      = {memREN, memWEN, memaddr, memstore};
   assign hold     = active && (key == key_q);
   assign wordIdx  = memaddr[IDX_W+1:2];

   // Any address bit above the array's word index means the request falls off the end.
   if (ADDR_W > IDX_W + 2) begin : gRange
      assign outOfRange = |memaddr[ADDR_W-1:IDX_W+2];
   end else begin : gNoRange
      assign outOfRange = 1'b0;
   end

   always_comb begin
      key_d       = key;
      cnt_d       = '0;
      age         = '0;
      ramstate    = FREE;
      legal       = 1'b0;
      firstAccess = 1'b0;
      rdCapture   = 1'b0;
      wrCommit    = 1'b0;

      if (hold) begin
         age   = cnt_q;
         cnt_d = satInc(cnt_q, LAT_SAT);
      end else if (active) begin
         cnt_d = 5'd1;
      end

      if (RST || !active) begin
         ramstate = FREE;
      end else if (conflict || outOfRange) begin
         ramstate = ERROR;
      end else if (age < LAT_C) begin
         ramstate = BUSY;
      end else begin
         ramstate = ACCESS;
      end

      // Reads capture one cycle early so data is ready when ACCESS first shows;
      // writes land exactly once, on the edge closing the first ACCESS cycle.
      legal       = active && !conflict && !outOfRange && !RST;
      firstAccess = legal && (age == LAT_C);
      rdCapture   = legal && memREN && (age == LAT_M1);
      wrCommit    = firstAccess && memWEN;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         key_q <= '0;
         cnt_q <= '0;
      end else begin
         key_q <= key_d;
         cnt_q <= cnt_d;
      end
   end

   ram_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk_i    (CLK),
      .rst_i    (RST),
      .wrEn_i   (wrCommit),
      .wrAddr_i (wordIdx),
      .wrData_i (memstore),
      .rdEn_i   (rdCapture),
      .rdAddr_i (wordIdx),
      .rdData_o (ramload)
   );

`ifdef RAM_STATS_EN
   logic [31:0] rdCount_q, rdCount_d;
   logic [31:0] wrCount_q, wrCount_d;

   always_comb begin
      rdCount_d = rdCount_q;
      wrCount_d = wrCount_q;
      if (firstAccess && memREN) begin
         rdCount_d = rdCount_q + 32'd1;
      end
      if (firstAccess && memWEN) begin
         wrCount_d = wrCount_q + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rdCount_q <= '0;
         wrCount_q <= '0;
      end else begin
         rdCount_q <= rdCount_d;
         wrCount_q <= wrCount_d;
      end
   end

   assign rd_count = rdCount_q;
   assign wr_count = wrCount_q;
`endif

endmodule

// File: tb/tb_ram_latency_ctrl.sv
// Scoreboard bench for ram_latency_ctrl (LAT=2, DEPTH=16384); RAM_STATS_EN adds the counter scenario.
module tb_ram_latency_ctrl;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] memaddr;
   word_t       memstore;
   logic        memREN;
   logic        memWEN;
   word_t       ramload;
   ramstate_t   ramstate;
`ifdef RAM_STATS_EN
   logic [31:0] rd_count;
   logic [31:0] wr_count;
`endif

   always #5 CLK = ~CLK;

   ram_latency_ctrl #(
      .LAT    (2),
      .DEPTH  (16384),
      .ADDR_W (32)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .memaddr  (memaddr),
      .memstore (memstore),
      .memREN   (memREN),
      .memWEN   (memWEN),
      .ramload  (ramload),
      .ramstate (ramstate)
`ifdef RAM_STATS_EN
     ,.rd_count (rd_count),
      .wr_count (wr_count)
`endif
   );

   typedef struct packed {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] data;
      logic        rst;
      ramstate_t   st;
      logic        chk;
      logic [31:0] load;
   } step_t;

   typedef struct packed {
      ramstate_t   st;
      logic        chk;
      logic [31:0] load;
   } exp_t;

   step_t plan[$];
   exp_t  expQ[$];
   int    checksTotal  = 0;
   int    checksPassed = 0;
   int    wrCommits    = 0;

   always @(posedge CLK) begin
      if (dut.wrCommit) wrCommits++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic addStep(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] data, input logic rst, input ramstate_t st,
                          input logic chk, input logic [31:0] load);
      plan.push_back('{ren, wen, addr, data, rst, st, chk, load});
   endtask

   task automatic applyStimulus(input step_t s);
      memREN   = s.ren;
      memWEN   = s.wen;
      memaddr  = s.addr;
      memstore = s.data;
      RST      = s.rst;
      expQ.push_back('{s.st, s.chk, s.load});
   endtask

   task automatic idleCycle();
      memREN = 1'b0;
      memWEN = 1'b0;
      RST    = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      for (int i = 0; i < 3; i++) begin
         memREN = 1'b0; memWEN = 1'b1; memaddr = addr; memstore = data; RST = 1'b0;
         @(posedge CLK); #1;
      end
      idleCycle();
   endtask

   task automatic test_reset();
      step_t s; exp_t e;
      addStep(1, 0, 32'h10, 32'h0, 1, FREE, 1, 32'h0);
      addStep(0, 1, 32'h20, 32'h5, 1, FREE, 1, 32'h0);
      while (plan.size() > 0) begin
         s = plan.pop_front(); applyStimulus(s);
         @(negedge CLK); e = expQ.pop_front();
         checksTotal++;
         if (ramstate !== e.st) $display("[TB] FAIL reset state: got %0d required %0d", ramstate, e.st);
         else checksPassed++;
         if (e.chk) begin
            checksTotal++;
            if (ramload !== e.load) $display("[TB] FAIL reset load: got %h required %h", ramload, e.load);
            else checksPassed++;
         end
         @(posedge CLK); #1;
      end
      idleCycle();
   endtask

   task automatic test_read();
      step_t s; exp_t e;
      preload(32'h10, 32'hDEADBEEF);
      addStep(1, 0, 32'h10, 32'h0, 0, BUSY,   0, 32'h0);
      addStep(1, 0, 32'h10, 32'h0, 0, BUSY,   0, 32'h0);
      addStep(1, 0, 32'h10, 32'h0, 0, ACCESS, 1, 32'hDEADBEEF);
      addStep(0, 0, 32'h0,  32'h0, 0, FREE,   1, 32'hDEADBEEF);
      while (plan.size() > 0) begin
         s = plan.pop_front(); applyStimulus(s);
         @(negedge CLK); e = expQ.pop_front();
         checksTotal++;
         if (ramstate !== e.st) $display("[TB] FAIL read state: got %0d required %0d", ramstate, e.st);
         else checksPassed++;
         if (e.chk) begin
            checksTotal++;
            if (ramload !== e.load) $display("[TB] FAIL read load: got %h required %h", ramload, e.load);
            else checksPassed++;
         end
         @(posedge CLK); #1;
      end
      idleCycle();
   endtask

   task automatic test_write();
      step_t s; exp_t e; int wc0;
      wc0 = wrCommits;
      addStep(0, 1, 32'h20, 32'h12345678, 0, BUSY, 0, 32'h0);
      addStep(0, 1, 32'h20, 32'h12345678, 0, BUSY, 0, 32'h0);
      for (int i = 0; i < 4; i++) addStep(0, 1, 32'h20, 32'h12345678, 0, ACCESS, 1, 32'hDEADBEEF);
      addStep(1, 0, 32'h20, 32'h0, 0, BUSY,   0, 32'h0);
      addStep(1, 0, 32'h20, 32'h0, 0, BUSY,   0, 32'h0);
      addStep(1, 0, 32'h20, 32'h0, 0, ACCESS, 1, 32'h12345678);
      while (plan.size() > 0) begin
         s = plan.pop_front(); applyStimulus(s);
         @(negedge CLK); e = expQ.pop_front();
         checksTotal++;
         if (ramstate !== e.st) $display("[TB] FAIL write state: got %0d required %0d", ramstate, e.st);
         else checksPassed++;
         if (e.chk) begin
            checksTotal++;
            if (ramload !== e.load) $display("[TB] FAIL write load: got %h required %h", ramload, e.load);
            else checksPassed++;
         end
         @(posedge CLK); #1;
      end
      idleCycle();
      checksTotal++;
      if (wrCommits - wc0 !== 1) $display("[TB] FAIL write count: got %0d required 1", wrCommits - wc0);
      else checksPassed++;
   endtask

   task automatic test_restart();
      step_t s; exp_t e;
      preload(32'h14, 32'hCAFEF00D);
      addStep(1, 0, 32'h10, 32'h0, 0, BUSY,   0, 32'h0);
      addStep(1, 0, 32'h14, 32'h0, 0, BUSY,   0, 32'h0);
      addStep(1, 0, 32'h14, 32'h0, 0, BUSY,   1, 32'h12345678);
      addStep(1, 0, 32'h14, 32'h0, 0, ACCESS, 1, 32'hCAFEF00D);
      while (plan.size() > 0) begin
         s = plan.pop_front(); applyStimulus(s);
         @(negedge CLK); e = expQ.pop_front();
         checksTotal++;
         if (ramstate !== e.st) $display("[TB] FAIL restart state: got %0d required %0d", ramstate, e.st);
         else checksPassed++;
         if (e.chk) begin
            checksTotal++;
            if (ramload !== e.load) $display("[TB] FAIL restart load: got %h required %h", ramload, e.load);
            else checksPassed++;
         end
         @(posedge CLK); #1;
      end
      idleCycle();
   endtask

   task automatic test_error();
      step_t s; exp_t e; int wc0;
      wc0 = wrCommits;
      for (int i = 0; i < 3; i++) addStep(1, 1, 32'h10,    32'h0BADBEEF, 0, ERROR, 1, 32'hCAFEF00D);
      for (int i = 0; i < 3; i++) addStep(0, 1, 32'h10000, 32'h11111111, 0, ERROR, 1, 32'hCAFEF00D);
      for (int i = 0; i < 3; i++) addStep(1, 0, 32'h10000, 32'h0,         0, ERROR, 1, 32'hCAFEF00D);
      addStep(1, 0, 32'h10, 32'h0, 0, BUSY,   0, 32'h0);
      addStep(1, 0, 32'h10, 32'h0, 0, BUSY,   0, 32'h0);
      addStep(1, 0, 32'h10, 32'h0, 0, ACCESS, 1, 32'hDEADBEEF);
      while (plan.size() > 0) begin
         s = plan.pop_front(); applyStimulus(s);
         @(negedge CLK); e = expQ.pop_front();
         checksTotal++;
         if (ramstate !== e.st) $display("[TB] FAIL error state: got %0d required %0d", ramstate, e.st);
         else checksPassed++;
         if (e.chk) begin
            checksTotal++;
            if (ramload !== e.load) $display("[TB] FAIL error load: got %h required %h", ramload, e.load);
            else checksPassed++;
         end
         @(posedge CLK); #1;
      end
      idleCycle();
      checksTotal++;
      if (wrCommits - wc0 !== 0) $display("[TB] FAIL error writes: got %0d required 0", wrCommits - wc0);
      else checksPassed++;
      // Last legal word sits right below the out-of-range boundary.
      preload(32'hFFFC, 32'h7777AAAA);
      addStep(1, 0, 32'hFFFC, 32'h0, 0, BUSY,   0, 32'h0);
      addStep(1, 0, 32'hFFFC, 32'h0, 0, BUSY,   0, 32'h0);
      addStep(1, 0, 32'hFFFC, 32'h0, 0, ACCESS, 1, 32'h7777AAAA);
      while (plan.size() > 0) begin
         s = plan.pop_front(); applyStimulus(s);
         @(negedge CLK); e = expQ.pop_front();
         checksTotal++;
         if (ramstate !== e.st) $display("[TB] FAIL top word state: got %0d required %0d", ramstate, e.st);
         else checksPassed++;
         if (e.chk) begin
            checksTotal++;
            if (ramload !== e.load) $display("[TB] FAIL top word load: got %h required %h", ramload, e.load);
            else checksPassed++;
         end
         @(posedge CLK); #1;
      end
      idleCycle();
   endtask

   task automatic test_reset_abort();
      step_t s; exp_t e; int wc0;
      preload(32'h30, 32'h5A5A0000);
      wc0 = wrCommits;
      addStep(0, 1, 32'h30, 32'hA5A5A5A5, 0, BUSY, 0, 32'h0);
      addStep(0, 1, 32'h30, 32'hA5A5A5A5, 0, BUSY, 0, 32'h0);
      addStep(0, 1, 32'h30, 32'hA5A5A5A5, 1, FREE, 0, 32'h0);
      addStep(0, 0, 32'h0,  32'h0,        0, FREE, 1, 32'h0);
      addStep(1, 0, 32'h30, 32'h0, 0, BUSY,   0, 32'h0);
      addStep(1, 0, 32'h30, 32'h0, 0, BUSY,   0, 32'h0);
      addStep(1, 0, 32'h30, 32'h0, 0, ACCESS, 1, 32'h5A5A0000);
      while (plan.size() > 0) begin
         s = plan.pop_front(); applyStimulus(s);
         @(negedge CLK); e = expQ.pop_front();
         checksTotal++;
         if (ramstate !== e.st) $display("[TB] FAIL abort state: got %0d required %0d", ramstate, e.st);
         else checksPassed++;
         if (e.chk) begin
            checksTotal++;
            if (ramload !== e.load) $display("[TB] FAIL abort load: got %h required %h", ramload, e.load);
            else checksPassed++;
         end
         @(posedge CLK); #1;
      end
      idleCycle();
      checksTotal++;
      if (wrCommits - wc0 !== 0) $display("[TB] FAIL abort writes: got %0d required 0", wrCommits - wc0);
      else checksPassed++;
   endtask

   task automatic test_back_to_back();
      step_t s; exp_t e;
      addStep(1, 0, 32'h10, 32'h0, 0, BUSY, 0, 32'h0);
      addStep(1, 0, 32'h10, 32'h0, 0, BUSY, 0, 32'h0);
      addStep(1, 0, 32'h10, 32'h0, 0, ACCESS, 1, 32'hDEADBEEF);
      addStep(0, 1, 32'h40, 32'h600DCAFE, 0, BUSY, 0, 32'h0);
      addStep(0, 1, 32'h40, 32'h600DCAFE, 0, BUSY, 0, 32'h0);
      addStep(0, 1, 32'h40, 32'h600DCAFE, 0, ACCESS, 1, 32'hDEADBEEF);
      addStep(1, 0, 32'h14, 32'h0, 0, BUSY, 0, 32'h0);
      addStep(1, 0, 32'h14, 32'h0, 0, BUSY, 0, 32'h0);
      addStep(1, 0, 32'h14, 32'h0, 0, ACCESS, 1, 32'hCAFEF00D);
      addStep(1, 0, 32'h40, 32'h0, 0, BUSY, 0, 32'h0);
      addStep(1, 0, 32'h40, 32'h0, 0, BUSY, 0, 32'h0);
      addStep(1, 0, 32'h40, 32'h0, 0, ACCESS, 1, 32'h600DCAFE);
      while (plan.size() > 0) begin
         s = plan.pop_front(); applyStimulus(s);
         @(negedge CLK); e = expQ.pop_front();
         checksTotal++;
         if (ramstate !== e.st) $display("[TB] FAIL b2b state: got %0d required %0d", ramstate, e.st);
         else checksPassed++;
         if (e.chk) begin
            checksTotal++;
            if (ramload !== e.load) $display("[TB] FAIL b2b load: got %h required %h", ramload, e.load);
            else checksPassed++;
         end
         @(posedge CLK); #1;
      end
      idleCycle();
   endtask

`ifdef RAM_STATS_EN
   task automatic test_stats();
      step_t s; exp_t e;
      addStep(0, 0, 32'h0, 32'h0, 1, FREE, 0, 32'h0);
      for (int r = 0; r < 3; r++) begin
         addStep(1, 0, 32'h10 + 32'(4 * r), 32'h0, 0, BUSY,   0, 32'h0);
         addStep(1, 0, 32'h10 + 32'(4 * r), 32'h0, 0, BUSY,   0, 32'h0);
         addStep(1, 0, 32'h10 + 32'(4 * r), 32'h0, 0, ACCESS, 0, 32'h0);
      end
      for (int w = 0; w < 2; w++) begin
         addStep(0, 1, 32'h50 + 32'(4 * w), 32'h99, 0, BUSY,   0, 32'h0);
         addStep(0, 1, 32'h50 + 32'(4 * w), 32'h99, 0, BUSY,   0, 32'h0);
         addStep(0, 1, 32'h50 + 32'(4 * w), 32'h99, 0, ACCESS, 0, 32'h0);
      end
      while (plan.size() > 0) begin
         s = plan.pop_front(); applyStimulus(s);
         @(negedge CLK); e = expQ.pop_front();
         checksTotal++;
         if (ramstate !== e.st) $display("[TB] FAIL stats state: got %0d required %0d", ramstate, e.st);
         else checksPassed++;
         @(posedge CLK); #1;
      end
      idleCycle();
      checksTotal++;
      if (rd_count !== 32'd3) $display("[TB] FAIL rd_count: got %0d required 3", rd_count);
      else checksPassed++;
      checksTotal++;
      if (wr_count !== 32'd2) $display("[TB] FAIL wr_count: got %0d required 2", wr_count);
      else checksPassed++;
      RST = 1'b1;
      @(posedge CLK); #1;
      checksTotal++;
      if (rd_count !== 32'd0 || wr_count !== 32'd0)
         $display("[TB] FAIL stats clear: got %0d/%0d required 0/0", rd_count, wr_count);
      else checksPassed++;
      idleCycle();
   endtask
`endif

   initial begin
      RST = 1'b1; memREN = 1'b0; memWEN = 1'b0; memaddr = '0; memstore = '0;
      repeat (2) @(posedge CLK);
      #1;
      $display("[TB] starting ram_latency_ctrl scenarios");
      test_reset();
      test_read();
      test_write();
      test_restart();
      test_error();
      test_reset_abort();
      test_back_to_back();
`ifdef RAM_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
